// File: rtl/port_seq.sv
// Table-driven port sequencer: plays up to eight 4-bit pattern entries,
// each held for DIV clock cycles, with pause, restart and abort control.
module port_seq #(
    parameter int           DIV      = 12000000,
    parameter bit           LOOP     = 1'b1,
    parameter logic [3:0]   IDLE_VAL = 4'b1010
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [2:0] last,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    output logic [3:0] data,
    output logic       busy,
    output logic [2:0] step,
    output logic       wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [2:0]      step_q, step_d;
    logic [2:0]      last_q, last_d;
    logic [3:0]      data_q, data_d;
    logic            wrap_q, wrap_d;
    logic [3:0]      tbl_q [8];
    logic [3:0]      tbl_d [8];

    always_comb begin
        tbl_d = tbl_q;
        if (wr_en) begin
            tbl_d[wr_addr] = wr_data;
        end
    end

    // Data is looked up from the pre-write table, so a same-cycle write
    // to the entry being shown appears one cycle later.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        step_d  = step_q;
        last_d  = last_q;
        data_d  = data_q;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            pre_d   = '0;
            step_d  = '0;
            data_d  = IDLE_VAL;
        end else if (start) begin
            state_d = RUN;
            pre_d   = '0;
            step_d  = '0;
            last_d  = last;
            data_d  = tbl_q[0];
        end else if (state_q != IDLE) begin
            if (pause) begin
                state_d = PAUSED;
            end else begin
                state_d = RUN;
                if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    if (step_q == last_q) begin
                        wrap_d = 1'b1;
                        step_d = '0;
                        if (!LOOP) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                data_d = (state_d == IDLE) ? IDLE_VAL : tbl_q[step_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pre_q   <= '0;
            step_q  <= '0;
            last_q  <= '0;
            data_q  <= IDLE_VAL;
            wrap_q  <= 1'b0;
            tbl_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            last_q  <= last_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
            tbl_q   <= tbl_d;
        end
    end

    assign data = data_q;
    assign busy = (state_q != IDLE);
    assign step = step_q;
    assign wrap = wrap_q;

endmodule
